// File: rtl/sim_run_ctrl_if.sv
// sim_run_ctrl_if: I/O-write, heartbeat and run-status bundle between the run controller and the bench
// Signals:
//   io_wr/io_addr/io_data  core I/O write strobe, address and data (exit code at halt)
//   hb_pulse               core activity pulse (used only by the stall watchdog)
//   rst_out                per-channel active-high reset to the DUT
//   run/done               DUT running / sticky end-of-run flag
//   timeout/stall          sticky end-of-run causes
//   exit_code/cycle_cnt    halt data or FF/FE code, saturating run-cycle count
// Modports: slave = controller side, master = bench/core side.
interface sim_run_ctrl_if #(
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 32,
    parameter int NUM_RST = 2
);
    logic               io_wr;
    logic [ADDR_W-1:0]  io_addr;
    logic [7:0]         io_data;
    logic               hb_pulse;
    logic [NUM_RST-1:0] rst_out;
    logic               run;
    logic               done;
    logic               timeout;
    logic               stall;
    logic [7:0]         exit_code;
    logic [CNT_W-1:0]   cycle_cnt;
    modport slave (
        input  io_wr, io_addr, io_data, hb_pulse,
        output rst_out, run, done, timeout, stall, exit_code, cycle_cnt
    );
    modport master (
        output io_wr, io_addr, io_data, hb_pulse,
        input  rst_out, run, done, timeout, stall, exit_code, cycle_cnt
    );
endinterface

// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: staggered reset release, run-cycle counting, halt/timeout/stall detection for the riscv_top bench
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any run and restarts the sequence
//   bus    sim_run_ctrl_if.slave (io_wr/io_addr/io_data/hb_pulse in; rst_out/run/done/timeout/stall/exit_code/cycle_cnt out)
// Optional feature: `define SIM_RUN_STALL_EN builds the heartbeat stall watchdog; otherwise stall is tied to 0.
module sim_run_ctrl #(
    parameter int                RST_CYCLES   = 25,
    parameter int                NUM_RST      = 2,
    parameter int                STAGGER      = 4,
    parameter int                TIMEOUT      = 150,
    parameter int                CNT_W        = 32,
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] HALT_ADDR    = ADDR_W'(32'h30004),
    parameter int                DRAIN_CYCLES = 8,
    parameter int                STALL_CYCLES = 1024
) (
    input logic          clk,
    input logic          rst_n,
    sim_run_ctrl_if.slave bus
);
    typedef enum logic [2:0] {HOLD, RELEASE, RUN, DRAIN, DONE} state_t;
    // Edge on which the last reset channel releases and run rises.
    localparam int LAST = RST_CYCLES + (NUM_RST - 1) * STAGGER;
    localparam int EC_W = $clog2(LAST + 1) + 1;
    localparam int DR_W = $clog2(DRAIN_CYCLES + 1) + 1;
    state_t             st_q, st_d;
    logic [EC_W-1:0]    ec_q, ec_d, ec_nx;
    logic [DR_W-1:0]    dr_q, dr_d;
    logic [NUM_RST-1:0] rst_out_q, rst_out_d;
    logic               run_q, run_d, done_q, done_d, to_q, to_d, stall_q, stall_d;
    logic [7:0]         code_q, code_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               halt, to_hit, stall_hit, dr_end;
    assign ec_nx  = ec_q + 1'b1;
    assign halt   = bus.io_wr && bus.io_addr == HALT_ADDR;
    assign to_hit = (TIMEOUT != 0) && cnt_q == CNT_W'(TIMEOUT - 1);
    // DRAIN lasts DRAIN_CYCLES edges; 0 and 1 both finish on the first drain edge.
    assign dr_end = (DRAIN_CYCLES <= 1) || dr_q == DR_W'(DRAIN_CYCLES - 1);
`ifdef SIM_RUN_STALL_EN
    localparam int ID_W = $clog2(STALL_CYCLES + 1) + 1;
    logic [ID_W-1:0] idle_q, idle_d, idle_nx;
    assign idle_nx   = bus.hb_pulse ? '0 : idle_q + 1'b1;
    assign stall_hit = !bus.hb_pulse && idle_nx == ID_W'(STALL_CYCLES);
    // Idle time is only accumulated while in RUN.
    assign idle_d    = (st_q == RUN) ? idle_nx : idle_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle_q <= '0;
        else        idle_q <= idle_d;
    end
`else
    logic unused_ok;
    assign stall_hit = 1'b0;
    assign unused_ok = &{1'b0, bus.hb_pulse, STALL_CYCLES == 0};
`endif
    always_comb begin
        st_d      = st_q;
        ec_d      = ec_q;
        dr_d      = dr_q;
        rst_out_d = rst_out_q;
        run_d     = run_q;
        done_d    = done_q;
        to_d      = to_q;
        stall_d   = stall_q;
        code_d    = code_q;
        cnt_d     = (run_q && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        case (st_q)
            HOLD, RELEASE: begin
                ec_d = ec_nx;
                for (int i = 0; i < NUM_RST; i++)
                    if (ec_nx == EC_W'(RST_CYCLES + i * STAGGER)) rst_out_d[i] = 1'b0;
                if (ec_nx == EC_W'(LAST)) begin
                    st_d  = RUN;
                    run_d = 1'b1;
                end else if (ec_nx == EC_W'(RST_CYCLES)) begin
                    st_d = RELEASE;
                end
            end
            RUN: begin
                if (halt) begin
                    code_d = bus.io_data;
                    dr_d   = '0;
                    st_d   = DRAIN;
                end else if (to_hit) begin
                    done_d = 1'b1;
                    to_d   = 1'b1;
                    run_d  = 1'b0;
                    code_d = 8'hFF;
                    st_d   = DONE;
                end else if (stall_hit) begin
                    done_d  = 1'b1;
                    stall_d = 1'b1;
                    run_d   = 1'b0;
                    code_d  = 8'hFE;
                    st_d    = DONE;
                end
            end
            DRAIN: begin
                dr_d = dr_q + 1'b1;
                if (dr_end) begin
                    done_d = 1'b1;
                    run_d  = 1'b0;
                    st_d   = DONE;
                end
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= HOLD;
            ec_q      <= '0;
            dr_q      <= '0;
            rst_out_q <= '1;
            run_q     <= 1'b0;
            done_q    <= 1'b0;
            to_q      <= 1'b0;
            stall_q   <= 1'b0;
            code_q    <= 8'h00;
            cnt_q     <= '0;
        end else begin
            st_q      <= st_d;
            ec_q      <= ec_d;
            dr_q      <= dr_d;
            rst_out_q <= rst_out_d;
            run_q     <= run_d;
            done_q    <= done_d;
            to_q      <= to_d;
            stall_q   <= stall_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
        end
    end
    assign bus.rst_out   = rst_out_q;
    assign bus.run       = run_q;
    assign bus.done      = done_q;
    assign bus.timeout   = to_q;
    assign bus.stall     = stall_q;
    assign bus.exit_code = code_q;
    assign bus.cycle_cnt = cnt_q;
endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl: directed bench for sim_run_ctrl (default parameters, STALL_CYCLES=16)
module tb_sim_run_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    always #5 clk = ~clk;
    sim_run_ctrl_if #(.ADDR_W(32), .CNT_W(32), .NUM_RST(2)) bus ();
    sim_run_ctrl #(.STALL_CYCLES(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic status(input string tag, input logic [1:0] ro, input logic r, input logic d,
                          input logic t, input logic s, input logic [7:0] ec, input logic [31:0] cc);
        chk({tag, ".rst_out"}, 64'(bus.rst_out), 64'(ro));
        chk({tag, ".run"}, 64'(bus.run), 64'(r));
        chk({tag, ".done"}, 64'(bus.done), 64'(d));
        chk({tag, ".timeout"}, 64'(bus.timeout), 64'(t));
        chk({tag, ".stall"}, 64'(bus.stall), 64'(s));
        chk({tag, ".exit_code"}, 64'(bus.exit_code), 64'(ec));
        chk({tag, ".cycle_cnt"}, 64'(bus.cycle_cnt), 64'(cc));
    endtask
    task automatic io_write(input logic [31:0] a, input logic [7:0] d);
        bus.io_wr = 1'b1;
        bus.io_addr = a;
        bus.io_data = d;
        step(1);
        bus.io_wr = 1'b0;
    endtask
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        status(tag, 2'b11, 0, 0, 0, 0, 8'h00, 0);
        step(3);
        rst_n = 1'b1;
    endtask
    initial begin
        bus.io_wr = 1'b0;
        bus.io_addr = '0;
        bus.io_data = '0;
        bus.hb_pulse = 1'b1;
        step(2);
        status("reset", 2'b11, 0, 0, 0, 0, 8'h00, 0);
        step(1);
        rst_n = 1'b1;
        step(10);
        io_write(32'h30004, 8'h55);
        step(13);
        status("e24", 2'b11, 0, 0, 0, 0, 8'h00, 0);
        step(1);
        status("e25", 2'b10, 0, 0, 0, 0, 8'h00, 0);
        step(3);
        status("e28", 2'b10, 0, 0, 0, 0, 8'h00, 0);
        step(1);
        status("e29", 2'b00, 1, 0, 0, 0, 8'h00, 0);
        step(20);
        io_write(32'h10030004, 8'hAA);
        status("bad_addr", 2'b00, 1, 0, 0, 0, 8'h00, 21);
        step(19);
        chk("cnt40", 64'(bus.cycle_cnt), 64'd40);
        io_write(32'h30004, 8'h00);
        status("drain1", 2'b00, 1, 0, 0, 0, 8'h00, 41);
        step(7);
        status("drain8", 2'b00, 1, 0, 0, 0, 8'h00, 48);
        step(1);
        status("halt_done", 2'b00, 0, 1, 0, 0, 8'h00, 49);
        step(5);
        status("halt_hold", 2'b00, 0, 1, 0, 0, 8'h00, 49);
        reset_pulse("rst_after_halt");
        step(29);
        status("run2", 2'b00, 1, 0, 0, 0, 8'h00, 0);
        step(149);
        status("pre_to", 2'b00, 1, 0, 0, 0, 8'h00, 149);
        step(1);
        status("timeout", 2'b00, 0, 1, 1, 0, 8'hFF, 150);
        step(3);
        status("to_hold", 2'b00, 0, 1, 1, 0, 8'hFF, 150);
        reset_pulse("rst_after_to");
        step(29 + 149);
        chk("tie_cnt", 64'(bus.cycle_cnt), 64'd149);
        io_write(32'h30004, 8'h5A);
        status("tie_drain", 2'b00, 1, 0, 0, 0, 8'h5A, 150);
        step(7);
        status("tie_drain8", 2'b00, 1, 0, 0, 0, 8'h5A, 157);
        step(1);
        status("tie_done", 2'b00, 0, 1, 0, 0, 8'h5A, 158);
        reset_pulse("rst_after_tie");
        step(29 + 5);
        io_write(32'h30004, 8'h3C);
        status("drain3c", 2'b00, 1, 0, 0, 0, 8'h3C, 6);
        step(3);
        reset_pulse("rst_in_drain");
        step(24);
        status("re24", 2'b11, 0, 0, 0, 0, 8'h00, 0);
        step(1);
        status("re25", 2'b10, 0, 0, 0, 0, 8'h00, 0);
        step(4);
        status("re29", 2'b00, 1, 0, 0, 0, 8'h00, 0);
        step(10);
        bus.hb_pulse = 1'b0;
        step(15);
        status("idle25", 2'b00, 1, 0, 0, 0, 8'h00, 25);
        step(1);
`ifdef SIM_RUN_STALL_EN
        status("stall", 2'b00, 0, 1, 0, 1, 8'hFE, 26);
        step(3);
        status("stall_hold", 2'b00, 0, 1, 0, 1, 8'hFE, 26);
`else
        status("no_stall", 2'b00, 1, 0, 0, 0, 8'h00, 26);
        step(3);
        status("no_stall3", 2'b00, 1, 0, 0, 0, 8'h00, 29);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
